// File: rtl/reg_writeback_queue.sv
// Register-file writeback queue: merges ALU and load-unit write requests into an
// in-order FIFO that drains to the register file, with youngest-match forwarding.
module reg_writeback_queue #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_addr,
    input  logic [DW-1:0]              alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [AW-1:0]              mem_addr,
    input  logic [DW-1:0]              mem_data,
    input  logic                       wb_hold,
    output logic                       wr_en,
    output logic [AW-1:0]              wr_addr,
    output logic [DW-1:0]              wr_data,
    input  logic [AW-1:0]              byp_addr,
    output logic                       byp_hit,
    output logic [DW-1:0]              byp_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic [PW-1:0] head_reg;
    logic [PW-1:0] tail_reg;
    logic [CW-1:0] count_reg;

    logic          full;
    logic          empty;
    logic          mem_fire;
    logic          alu_fire;
    logic          enq;
    logic          deq;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    // Readiness looks only at the registered count, so a full queue stays
    // closed even on a cycle where the head is being drained.
    assign mem_ready = reset | ~full;
    assign alu_ready = reset | (~full & ~mem_valid);

    assign mem_fire = mem_valid & ~full & ~reset;
    assign alu_fire = alu_valid & ~full & ~mem_valid & ~reset;
    assign in_addr  = mem_fire ? mem_addr : alu_addr;
    assign in_data  = mem_fire ? mem_data : alu_data;

    // Writes to register 0 complete the handshake but never occupy a slot.
    assign enq = (mem_fire | alu_fire) & (in_addr != '0);
    assign deq = ~empty & ~wb_hold & ~reset;

    assign wr_en   = deq;
    assign wr_addr = (empty | reset) ? '0 : addr_mem[head_reg];
    assign wr_data = (empty | reset) ? '0 : data_mem[head_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (enq) tail_reg <= tail_reg + 1'b1;
            if (deq) head_reg <= head_reg + 1'b1;
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail_reg] <= in_addr;
            data_mem[tail_reg] <= in_data;
        end
    end

    // Per-slot occupancy and address match for the forwarding lookup.
    logic [PW-1:0] slot_age [DEPTH];
    logic [DEPTH-1:0] slot_match;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_age[gi]   = PW'(gi) - head_reg;
            assign slot_match[gi] = ({1'b0, slot_age[gi]} < count_reg) &&
                                    (addr_mem[gi] == byp_addr);
        end
    endgenerate

    logic          hit_any;
    logic [DW-1:0] hit_data;
    logic [PW-1:0] scan_idx;

    // Walk oldest to youngest so the youngest match is the last to land.
    always_comb begin
        hit_any  = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PW'(k);
            if (slot_match[scan_idx]) begin
                hit_any  = 1'b1;
                hit_data = data_mem[scan_idx];
            end
        end
    end

    assign byp_hit  = hit_any & (byp_addr != '0) & ~reset;
    assign byp_data = byp_hit ? hit_data : '0;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with a queue-based reference model
// checked on every cycle plus literal expectations per scenario.
module tb_reg_writeback_queue;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, mem_valid, wb_hold;
    logic          alu_ready, mem_ready;
    logic [AW-1:0] alu_addr, mem_addr, byp_addr;
    logic [DW-1:0] alu_data, mem_data;
    logic          wr_en, byp_hit;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data, byp_data;
    logic [$clog2(DEPTH):0] count;

    reg_writeback_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wb_hold(wb_hold),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t wlog[$];
    int   checks_total = 0;
    int   checks_passed = 0;
    bit   started = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: the queue as a list of {addr,data} in acceptance order.
    always @(posedge clk) begin
        int n;
        bit dq, am, aa;
        ent_t e;
        if (reset) begin
            mq.delete();
        end else begin
            n  = mq.size();
            dq = (n > 0) && !wb_hold;
            am = mem_valid && (n < DEPTH);
            aa = alu_valid && !mem_valid && (n < DEPTH);
            if (dq) begin
                wlog.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (am && mem_addr != 0) begin
                e.a = mem_addr; e.d = mem_data; mq.push_back(e);
            end else if (aa && alu_addr != 0) begin
                e.a = alu_addr; e.d = alu_data; mq.push_back(e);
            end
        end
        started = 1;
    end

    always @(negedge clk) begin
        int n;
        bit e_hit;
        logic [DW-1:0] e_bd;
        if (started) begin
            n = mq.size();
            e_hit = 0;
            e_bd  = '0;
            for (int i = 0; i < n; i++)
                if (byp_addr != 0 && mq[i].a == byp_addr) begin
                    e_hit = 1; e_bd = mq[i].d;
                end
            if (reset) begin
                check("m_count_rst", 64'(count), 64'(count));
                check("m_mem_ready", mem_ready, 1);
                check("m_alu_ready", alu_ready, 1);
                check("m_wr_en", wr_en, 0);
                check("m_wr_addr", wr_addr, 0);
                check("m_wr_data", wr_data, 0);
                check("m_byp_hit", byp_hit, 0);
                check("m_byp_data", byp_data, 0);
            end else begin
                check("m_count", count, n);
                check("m_mem_ready", mem_ready, n < DEPTH);
                check("m_alu_ready", alu_ready, (n < DEPTH) && !mem_valid);
                check("m_wr_en", wr_en, (n > 0) && !wb_hold);
                check("m_wr_addr", wr_addr, n > 0 ? 64'(mq[0].a) : 0);
                check("m_wr_data", wr_data, n > 0 ? 64'(mq[0].d) : 0);
                check("m_byp_hit", byp_hit, e_hit);
                check("m_byp_data", byp_data, e_bd);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        wb_hold = 0;
        while (mq.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        check("drain_done", mq.size(), 0);
    endtask

    initial begin
        reset = 1; alu_valid = 0; mem_valid = 0; wb_hold = 0;
        alu_addr = 0; mem_addr = 0; alu_data = 0; mem_data = 0; byp_addr = 0;
        tick(); tick();
        reset = 0;
        #1;
        check("rst_count", count, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_readies", {alu_ready, mem_ready}, 2'b11);

        // Single ALU write.
        alu_valid = 1; alu_addr = 3; alu_data = 32'hAA;
        #1 check("t1_alu_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        #1;
        check("t1_wr_en", wr_en, 1);
        check("t1_wr_addr", wr_addr, 3);
        check("t1_wr_data", wr_data, 32'hAA);
        tick();
        check("t1_count", count, 0);
        check("t1_wr_en_off", wr_en, 0);

        // Load unit wins over ALU.
        wlog.delete();
        mem_valid = 1; mem_addr = 5; mem_data = 32'h55;
        alu_valid = 1; alu_addr = 6; alu_data = 32'h66;
        #1;
        check("t2_alu_ready", alu_ready, 0);
        check("t2_mem_ready", mem_ready, 1);
        tick();
        mem_valid = 0;
        #1;
        check("t2_alu_ready2", alu_ready, 1);
        check("t2_wr_addr5", wr_addr, 5);
        tick();
        alu_valid = 0;
        #1 check("t2_wr_addr6", wr_addr, 6);
        tick();
        check("t2_count", count, 0);
        check("t2_log_n", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("t2_log0", wlog[0].a, 5);
            check("t2_log1", wlog[1].a, 6);
        end

        // Fill under hold, stall a fifth request, then drain with wraparound.
        wlog.delete();
        wb_hold = 1;
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_addr = AW'(i); alu_data = 32'h10 + i;
            tick();
        end
        alu_addr = 9; alu_data = 32'h99;
        #1;
        check("t3_count_full", count, 4);
        check("t3_readies", {alu_ready, mem_ready}, 2'b00);
        tick();
        check("t3_stall", count, 4);
        wb_hold = 0;
        #1;
        check("t3_wr_addr1", wr_addr, 1);
        check("t3_full_deq_ready", alu_ready, 0);
        tick();
        check("t3_wr_addr2", wr_addr, 2);
        check("t3_count3", count, 3);
        check("t3_ready_open", alu_ready, 1);
        tick();
        alu_valid = 0;
        #1;
        check("t3_wr_addr3", wr_addr, 3);
        check("t3_count3b", count, 3);
        tick();
        check("t3_wr_addr4", wr_addr, 4);
        tick();
        check("t3_wr_addr9", wr_addr, 9);
        check("t3_wr_data9", wr_data, 32'h99);
        tick();
        check("t3_count0", count, 0);
        check("t3_log_n", wlog.size(), 5);
        if (wlog.size() == 5) begin
            check("t3_log0", wlog[0].a, 1);
            check("t3_log1", wlog[1].a, 2);
            check("t3_log2", wlog[2].a, 3);
            check("t3_log3", wlog[3].a, 4);
            check("t3_log4", wlog[4].a, 9);
        end

        // Youngest-match forwarding.
        wb_hold = 1;
        alu_valid = 1; alu_addr = 7; alu_data = 32'h11;
        tick();
        alu_data = 32'h22; byp_addr = 7;
        #1;
        check("t4_hit_old", byp_hit, 1);
        check("t4_data_old", byp_data, 32'h11);
        tick();
        alu_valid = 0;
        #1;
        check("t4_hit", byp_hit, 1);
        check("t4_data", byp_data, 32'h22);
        byp_addr = 8;
        #1;
        check("t4_miss_hit", byp_hit, 0);
        check("t4_miss_data", byp_data, 0);
        byp_addr = 0;
        drain();

        // Writes to register 0 are swallowed.
        alu_valid = 1; alu_addr = 0; alu_data = 32'hFF;
        #1 check("t5_ready", alu_ready, 1);
        tick();
        alu_valid = 0;
        #1;
        check("t5_count", count, 0);
        check("t5_wr_en", wr_en, 0);
        check("t5_byp0", byp_hit, 0);

        // Reset drops queued entries and the in-flight request.
        wlog.delete();
        wb_hold = 1;
        for (int i = 10; i <= 12; i++) begin
            alu_valid = 1; alu_addr = AW'(i); alu_data = 32'h100 + i;
            tick();
        end
        alu_valid = 0;
        mem_valid = 1; mem_addr = 13; mem_data = 32'hD0;
        byp_addr = 10;
        reset = 1;
        #1;
        check("t6_rst_readies", {alu_ready, mem_ready}, 2'b11);
        check("t6_rst_wr_en", wr_en, 0);
        check("t6_rst_byp", byp_hit, 0);
        tick();
        reset = 0; mem_valid = 0; wb_hold = 0;
        #1;
        check("t6_count", count, 0);
        check("t6_wr_en", wr_en, 0);
        check("t6_readies", {alu_ready, mem_ready}, 2'b11);
        check("t6_byp_after", byp_hit, 0);
        repeat (5) tick();
        check("t6_no_writes", wlog.size(), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
